stream_credit_tx: RTL and testbench
===================================

// Module: stream_credit_tx
// PURPOSE
//  Transmit end of the credit-flow-controlled link whose receive side is a skid-buffered sink.
//  Accepts a valid/ready stream from upstream and drives a valid-only link toward the receiver.
//  Each beat consumes one credit; the receiver returns one credit per freed buffer slot.
//  The link never stalls, so the receiver needs no ready path, which breaks the long
//  ready-timing path across the PCIe datapath boundary.
// PARAMETERS
//  DW            8   data width in bits
//  CREDITS       4   receiver buffer depth = initial credit count, >=1
//  CW            $clog2(CREDITS+1)  credit counter width
//  OPT_LOWPOWER  0   1: o_data forced to 0 whenever o_valid is low
// PORTS
//  i_clk            in   1    clock, all logic on rising edge
//  i_reset          in   1    synchronous reset, active high
//  i_valid          in   1    upstream beat valid
//  o_ready          out  1    upstream may transfer (i_valid && o_ready = accept)
//  i_data           in   DW   upstream beat data
//  o_valid          out  1    link beat valid, one-cycle strobe per beat, no backpressure
//  o_data           out  DW   link beat data
//  i_credit_return  in   1    one credit returned per cycle asserted
//  o_credits        out  CW   current available credit count
//  o_err            out  1    sticky credit-overflow flag
// BEHAVIOUR
//  Reset:
//  - Next edge after i_reset: o_valid=0, o_data=0, o_credits=CREDITS, o_err=0.
//  - i_valid and i_credit_return are ignored while i_reset is high.
//  Upstream handshake:
//  - o_ready = (o_credits != 0). Driven only from registered state; no combinational path
//    from i_valid or i_credit_return.
//  - Accept = i_valid && o_ready && !i_reset.
//  - Upstream holds i_data stable while i_valid && !o_ready.
//  Link output:
//  - Fully registered, latency 1.
//  - Accept in cycle N: o_valid=1 and o_data=i_data(N) in cycle N+1.
//  - No accept in cycle N: o_valid=0 in N+1.
//  - Back-to-back accepts give back-to-back o_valid pulses.
//  - OPT_LOWPOWER=0: o_data holds the last beat when idle.
//  - OPT_LOWPOWER=1: o_data=0 when idle.
//  Credit counter update (next = cur - accept + return):
//  - Accept only: decrement. Never underflows, because accept requires credits != 0.
//  - Return only: increment.
//  - Accept and return in the same cycle: count unchanged.
//  - A credit returned while the count is 0 is usable the next cycle.
//    Bubble: o_ready rises one cycle after the return.
//  - Return with count==CREDITS and no accept is an overflow:
//    count stays CREDITS, o_err is set next cycle and stays high until reset.
//  - Return at CREDITS together with an accept is legal: count unchanged, no error.
//  Reset mid-operation:
//  - Any in-flight o_valid is dropped and credits reload to CREDITS.
//  - The receiver is reset in the same cycle; this is a system-level requirement.
//  Invariant:
//  - o_credits + beats sent - credits returned == CREDITS.
// TESTING
//  T1 CREDITS=4, after reset, drive 0x11,0x12,0x13,0x14 back-to-back, no returns
//     -> o_valid high cycles 1-4 with those bytes; o_ready low after 4th accept; o_credits=0.
//  T2 credits=0, i_valid high, pulse i_credit_return in cycle N
//     -> o_ready=1 in N+1, beat accepted, o_valid in N+2, o_credits=0 again.
//  T3 credits=2, accept and return in the same cycle -> o_credits stays 2, o_err=0.
//  T4 credits=4, no accept, pulse return -> o_credits=4, o_err=1 next cycle;
//     o_err stays 1 through 10 idle cycles; clears only on reset.
//  T5 o_valid=1, credits=1, o_err=1, assert i_reset one cycle
//     -> next cycle o_valid=0, o_credits=4, o_err=0, o_ready=1.
//  T6 OPT_LOWPOWER=1, random traffic and returns
//     -> o_data==0 whenever !o_valid; credit invariant holds every cycle.

Source files
------------

// File: rtl/stream_credit_tx.sv
// Transmit side of a credit-flow-controlled link.
// Takes a valid/ready stream from upstream and forwards each accepted beat,
// one cycle later, on a valid-only link. Each beat spends one credit, and the
// receiver returns one credit per freed buffer slot. Upstream ready depends
// only on the registered credit count, so no ready path runs back across the
// link. A credit returned while the count is already full is an overflow. It
// sets a sticky error flag.
module stream_credit_tx #(
    parameter int DW           = 8,
    parameter int CREDITS      = 4,
    parameter int CW           = $clog2(CREDITS + 1),
    parameter bit OPT_LOWPOWER = 1'b0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    input  logic          i_credit_return,
    output logic [CW-1:0] o_credits,
    output logic          o_err
);

    localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

    // Next credit count. A spend and a return in the same cycle cancel out.
    // A lone return at the full count saturates at the full count.
    function automatic logic [CW-1:0] credit_update(
        input logic [CW-1:0] cur,
        input logic          take,
        input logic          give
    );
        logic [CW-1:0] nxt;
        nxt = cur;
        if (take && !give) begin
            nxt = cur - CW'(1);
        end else if (give && !take) begin
            nxt = (cur == CREDIT_MAX) ? CREDIT_MAX : cur + CW'(1);
        end
        return nxt;
    endfunction

    // A lone return that arrives at the full count has no slot to fill.
    function automatic logic credit_overflow(
        input logic [CW-1:0] cur,
        input logic          take,
        input logic          give
    );
        return give && !take && (cur == CREDIT_MAX);
    endfunction

    logic          ready_p0;
    logic          accept_p0;
    logic          vld_p1;
    logic [DW-1:0] data_p1;
    logic [CW-1:0] credits_p1;
    logic          err_p1;

    // Stage 0: upstream handshake. Ready comes only from the credit register.
    assign ready_p0  = (credits_p1 != '0);
    assign accept_p0 = i_valid && ready_p0 && !i_reset;

    // Register the link beat: one strobe for each accepted beat.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept_p0;
        end
    end

    // Register the link data. It holds the last beat, or is zeroed when idle in low-power mode.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            data_p1 <= '0;
        end else if (accept_p0) begin
            data_p1 <= i_data;
        end else if (OPT_LOWPOWER) begin
            data_p1 <= '0;
        end
    end

    // Credit counter: spend on accept, refill on return, reload on reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            credits_p1 <= CREDIT_MAX;
        end else begin
            credits_p1 <= credit_update(credits_p1, accept_p0, i_credit_return);
        end
    end

    // Sticky overflow flag. It clears only on reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            err_p1 <= 1'b0;
        end else if (credit_overflow(credits_p1, accept_p0, i_credit_return)) begin
            err_p1 <= 1'b1;
        end
    end

    // Stage 1: registered link outputs.
    assign o_ready   = ready_p0;
    assign o_valid   = vld_p1;
    assign o_data    = data_p1;
    assign o_credits = credits_p1;
    assign o_err     = err_p1;

endmodule

// File: tb/tb_stream_credit_tx.sv
// Bench for stream_credit_tx: directed vector table, hand sequences for the
// credit-starved and sticky-error corners, then random traffic on a normal
// and a low-power instance against an arithmetic credit model.
module tb_stream_credit_tx;

    localparam int DW      = 8;
    localparam int CREDITS = 4;
    localparam int CW      = $clog2(CREDITS + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid = 1'b0;
    logic [DW-1:0] data = '0;
    logic          ret = 1'b0;

    logic          ready_a, vld_a, err_a;
    logic [DW-1:0] data_a;
    logic [CW-1:0] cred_a;
    logic          ready_b, vld_b, err_b;
    logic [DW-1:0] data_b;
    logic [CW-1:0] cred_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    stream_credit_tx #(.DW(DW), .CREDITS(CREDITS), .OPT_LOWPOWER(1'b0)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .o_ready(ready_a),
        .i_data(data), .o_valid(vld_a), .o_data(data_a),
        .i_credit_return(ret), .o_credits(cred_a), .o_err(err_a)
    );

    stream_credit_tx #(.DW(DW), .CREDITS(CREDITS), .OPT_LOWPOWER(1'b1)) dut_lp (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .o_ready(ready_b),
        .i_data(data), .o_valid(vld_b), .o_data(data_b),
        .i_credit_return(ret), .o_credits(cred_b), .o_err(err_b)
    );

    typedef struct {
        logic          rst;
        logic          valid;
        logic [DW-1:0] data;
        logic          ret;
        logic          e_valid;
        logic [DW-1:0] e_data;
        int            e_cred;
        logic          e_ready;
        logic          e_err;
    } vec_t;

    // Reference state: credits as a plain integer, beat counts since reset.
    int            m_cred;
    logic          m_vld;
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_lpdata;
    logic          m_err;
    int            m_sent;
    int            m_rtn;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [DW-1:0] d, input logic cr);
        @(negedge clk);
        rst = r; valid = v; data = d; ret = cr;
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input logic r, input logic v, input logic [DW-1:0] d, input logic cr);
        bit acc;
        if (r) begin
            m_cred = CREDITS; m_vld = 0; m_data = '0; m_lpdata = '0;
            m_err = 0; m_sent = 0; m_rtn = 0;
        end else begin
            acc = v && (m_cred > 0);
            m_vld = acc;
            if (acc) m_data = d;
            m_lpdata = acc ? d : '0;
            m_cred = m_cred - int'(acc) + int'(cr);
            if (acc) m_sent++;
            if (cr) m_rtn++;
            if (m_cred > CREDITS) begin
                m_cred = CREDITS;
                m_err = 1;
                m_rtn--;
            end
        end
    endtask

    task automatic idle_err_check(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b0);
            check("t4_err_sticky", int'(err_a), 1);
            check("t4_cred_idle", int'(cred_a), CREDITS);
        end
    endtask

    vec_t vecs[18];

    initial begin
        //                rst v  data   ret ev  edata  cred rdy err
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 3, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 8'h12, 2, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 8'h13, 1'b0, 1'b1, 8'h13, 1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'h14, 1'b0, 1'b1, 8'h14, 0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 8'h99, 1'b0, 1'b0, 8'h14, 0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h14, 1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h14, 2, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'h21, 1'b1, 1'b1, 8'h21, 2, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h21, 3, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h21, 4, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h21, 4, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 8'h31, 1'b1, 1'b1, 8'h31, 4, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 8'h41, 1'b0, 1'b1, 8'h41, 3, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 8'h42, 1'b0, 1'b1, 8'h42, 2, 1'b1, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 8'h43, 1'b0, 1'b1, 8'h43, 1, 1'b1, 1'b1};
        vecs[16] = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 4, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4, 1'b1, 1'b0};

        // Directed table: burst, same-cycle spend/return, overflow, reset mid-flight.
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].ret);
            check($sformatf("vec%0d_valid", i), int'(vld_a), int'(vecs[i].e_valid));
            if (vecs[i].e_valid || vecs[i].rst)
                check($sformatf("vec%0d_data", i), int'(data_a), int'(vecs[i].e_data));
            check($sformatf("vec%0d_cred", i), int'(cred_a), vecs[i].e_cred);
            check($sformatf("vec%0d_ready", i), int'(ready_a), int'(vecs[i].e_ready));
            check($sformatf("vec%0d_err", i), int'(err_a), int'(vecs[i].e_err));
            if (i == 11) idle_err_check(10);
        end

        // Credit-starved upstream: the return enables exactly one more beat.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'h60 + 8'(i), 1'b0);
        drive(1'b0, 1'b1, 8'h77, 1'b0);
        check("t2_starved_valid", int'(vld_a), 0);
        check("t2_starved_ready", int'(ready_a), 0);
        drive(1'b0, 1'b1, 8'h77, 1'b1);
        check("t2_ret_ready", int'(ready_a), 1);
        check("t2_ret_valid", int'(vld_a), 0);
        check("t2_ret_cred", int'(cred_a), 1);
        drive(1'b0, 1'b1, 8'h77, 1'b0);
        check("t2_beat_valid", int'(vld_a), 1);
        check("t2_beat_data", int'(data_a), 8'h77);
        check("t2_beat_cred", int'(cred_a), 0);
        check("t2_beat_ready", int'(ready_a), 0);

        // Random traffic on both instances against the model.
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        model_step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int n = 0; n < 2000; n++) begin
            logic          r, v, cr;
            logic [DW-1:0] d;
            r  = ($urandom_range(0, 63) == 0);
            v  = ($urandom_range(0, 1) == 1);
            cr = ($urandom_range(0, 9) < 4);
            d  = DW'($urandom);
            drive(r, v, d, cr);
            model_step(r, v, d, cr);
            check("rnd_valid", int'(vld_a), int'(m_vld));
            check("rnd_data", int'(data_a), int'(m_data));
            check("rnd_cred", int'(cred_a), m_cred);
            check("rnd_ready", int'(ready_a), int'(m_cred != 0));
            check("rnd_err", int'(err_a), int'(m_err));
            check("rnd_lp_valid", int'(vld_b), int'(m_vld));
            check("rnd_lp_data", int'(data_b), int'(m_lpdata));
            check("rnd_lp_cred", int'(cred_b), m_cred);
            check("rnd_lp_err", int'(err_b), int'(m_err));
            check("rnd_invariant", int'(cred_b) + m_sent - m_rtn, CREDITS);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
